inst_fetch: RTL

Instruction fetch initiator for the synchronous instruction ROM. The ROM returns the word for address A one clock after A is sampled.
- Generates sequential word addresses from a PC register.
- Tracks the single in-flight ROM read.
- Buffers returned words in a 2-entry skid FIFO.
- Presents {instruction, PC} to decode over a valid/ready handshake.
- Accepts control-flow redirects from execute.

---
 rtl/shrv32_pkg.sv | 15 +
 rtl/fetch_skid_fifo.sv | 65 ++++++
 rtl/inst_fetch.sv | 87 ++++++++
 3 files changed

// File: rtl/shrv32_pkg.sv
// Shared types and constants for the shrv32 front end.
// Fetch packets carry an instruction word together with its byte address.
package shrv32_pkg;

   localparam int XLEN       = 32;
   localparam int WORD_BYTES = 4;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid buffer for fetched {inst, pc} packets.
// Slot 0 is always the head; flush wins over push and pop.
module fetch_skid_fifo
   import shrv32_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  fetch_pkt_t push_pkt,
   input  logic       pop,
   input  logic       flush,
   output logic [1:0] count,
   output fetch_pkt_t head
);

   fetch_pkt_t slot0_q, slot0_d;
   fetch_pkt_t slot1_q, slot1_d;
   logic [1:0] count_q, count_d;

   logic       do_pop;
   logic [1:0] level;

   // Next-state: drop the head on pop, then append into the first free slot.
   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      count_d = count_q;
      do_pop  = pop & (count_q != 2'd0);
      level   = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         if (do_pop) begin
            slot0_d = slot1_q;
            level   = count_q - 2'd1;
         end
         if (push && (level != 2'd2)) begin
            if (level == 2'd0) begin
               slot0_d = push_pkt;
            end else begin
               slot1_d = push_pkt;
            end
            level = level + 2'd1;
         end
         count_d = level;
      end
   end

   // Storage and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= 2'd0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign head  = (count_q == 2'd0) ? '0 : slot0_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch initiator for a 1-cycle synchronous ROM.
// Credit-based issue keeps the skid FIFO from ever overflowing.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          XLEN     = 32
) (
   input  logic            CLK,
   input  logic            RST,
   output logic [XLEN-1:0] IMEM_A,
   input  logic [XLEN-1:0] IMEM_RD,
   input  logic            REDIRECT,
   input  logic [XLEN-1:0] REDIRECT_PC,
   output logic            INST_VALID,
   input  logic            INST_READY,
   output logic [XLEN-1:0] INST,
   output logic [XLEN-1:0] INST_PC
);

   import shrv32_pkg::*;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic            inflight_q, inflight_d;

   logic       pop;
   logic       push;
   logic       issue;
   logic [2:0] credit;
   logic [1:0] count;

   fetch_pkt_t push_pkt;
   fetch_pkt_t head;

   assign pop    = INST_VALID & INST_READY & ~REDIRECT;
   assign push   = inflight_q & ~REDIRECT;
   assign credit = {1'b0, count}
                 + {2'b00, inflight_q}
                 - {2'b00, pop};
   assign issue  = ~REDIRECT & (credit < 3'd2);

   assign push_pkt.inst = IMEM_RD;
   assign push_pkt.pc   = inflight_pc_q;

   // Next fetch address and in-flight tracking; a redirect cancels everything.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      if (REDIRECT) begin
         fetch_pc_d = {REDIRECT_PC[XLEN-1:2], 2'b00};
      end else if (issue) begin
         inflight_d    = 1'b1;
         inflight_pc_d = fetch_pc_q;
         fetch_pc_d    = fetch_pc_q + XLEN'(WORD_BYTES);
      end
   end

   // Fetch PC and in-flight read registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   fetch_skid_fifo u_fifo (
      .clk      (CLK),
      .rst      (RST),
      .push     (push),
      .push_pkt (push_pkt),
      .pop      (pop),
      .flush    (REDIRECT),
      .count    (count),
      .head     (head)
   );

   assign IMEM_A     = fetch_pc_q;
   assign INST_VALID = (count != 2'd0);
   assign INST       = head.inst;
   assign INST_PC    = head.pc;

endmodule
